// File: rtl/fifo_drain_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_drain_arbiter
//  Description : Round-robin drain of four output FIFOs (4..7) into a single
//                registered, backpressured downstream word stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_drain_arbiter #(
    parameter int data_width = 10,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            empty_fifos,
    input  logic [data_width-1:0] FIFO_data_out4,
    input  logic [data_width-1:0] FIFO_data_out5,
    input  logic [data_width-1:0] FIFO_data_out6,
    input  logic [data_width-1:0] FIFO_data_out7,
    output logic                  pop4,
    output logic                  pop5,
    output logic                  pop6,
    output logic                  pop7,
    input  logic                  ready_in,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    output logic [1:0]            dest_out,
    output logic [cnt_width-1:0]  cnt4,
    output logic [cnt_width-1:0]  cnt5,
    output logic [cnt_width-1:0]  cnt6,
    output logic [cnt_width-1:0]  cnt7,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_POP  = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_sel;
    logic [1:0]            r_last;
    logic [1:0]            w_rr_sel;
    logic                  w_any_avail;
    logic [data_width-1:0] w_fifo_data;
    logic [data_width-1:0] r_data;
    logic                  r_valid;
    logic [1:0]            r_dest;
    logic [cnt_width-1:0]  r_cnt [4];

    assign w_any_avail = ~&empty_fifos;

    // Scan from farthest to nearest so the first non-empty index after r_last wins.
    always_comb begin
        logic [1:0] v_idx;
        w_rr_sel = r_last;
        for (int i = 4; i >= 1; i--) begin
            v_idx = r_last + 2'(i);
            if (!empty_fifos[v_idx]) begin
                w_rr_sel = v_idx;
            end
        end
    end

    always_comb begin
        w_fifo_data = FIFO_data_out4;
        case (r_sel)
            2'd0:    w_fifo_data = FIFO_data_out4;
            2'd1:    w_fifo_data = FIFO_data_out5;
            2'd2:    w_fifo_data = FIFO_data_out6;
            default: w_fifo_data = FIFO_data_out7;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any_avail) w_state_nxt = ST_POP;
            ST_POP:  w_state_nxt = ST_CAPT;
            ST_CAPT: w_state_nxt = ST_HOLD;
            ST_HOLD: if (ready_in) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_dest  <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_avail) r_sel <= w_rr_sel;
                end
                ST_CAPT: begin
                    r_data  <= w_fifo_data;
                    r_dest  <= r_sel;
                    r_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (ready_in) begin
                        r_valid      <= 1'b0;
                        r_last       <= r_sel;
                        r_cnt[r_sel] <= r_cnt[r_sel] + cnt_width'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Read strobes are decoded from the registered state so they drop with reset.
    assign pop4 = (r_state == ST_POP) && (r_sel == 2'd0);
    assign pop5 = (r_state == ST_POP) && (r_sel == 2'd1);
    assign pop6 = (r_state == ST_POP) && (r_sel == 2'd2);
    assign pop7 = (r_state == ST_POP) && (r_sel == 2'd3);

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign dest_out  = r_dest;
    assign cnt4      = r_cnt[0];
    assign cnt5      = r_cnt[1];
    assign cnt6      = r_cnt[2];
    assign cnt7      = r_cnt[3];
    assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire
